// File: rtl/fifo_ctrl_core.sv
// rtl/fifo_ctrl_core.sv - 8-entry synchronous FIFO core: op state, occupancy, pointers, storage and registered read data
module fifo_ctrl_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] W_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] W_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_WRITE  = 3'b001,
        ST_WR_ERR = 3'b010,
        ST_NO_OP  = 3'b011,
        ST_READ   = 3'b100,
        ST_RD_ERR = 3'b101
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Decision uses the pre-edge count; simultaneous requests fall through to NO_OP.
    always_comb begin
        w_state_nxt = ST_NO_OP;
        w_do_wr     = 1'b0;
        w_do_rd     = 1'b0;
        if (wr_en && !rd_en) begin
            if (r_count < W_DEPTH) begin
                w_state_nxt = ST_WRITE;
                w_do_wr     = 1'b1;
            end else begin
                w_state_nxt = ST_WR_ERR;
            end
        end else if (rd_en && !wr_en) begin
            if (r_count != '0) begin
                w_state_nxt = ST_READ;
                w_do_rd     = 1'b1;
            end else begin
                w_state_nxt = ST_RD_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_do_wr) begin
                r_tail  <= r_tail + 1'b1;
                r_count <= r_count + W_ONE;
            end
            if (w_do_rd) begin
                r_dout  <= r_mem[r_head];
                r_head  <= r_head + 1'b1;
                r_count <= r_count - W_ONE;
            end
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (!reset && w_do_wr) begin
            r_mem[r_tail] <= d_in;
        end
    end

    assign state      = r_state;
    assign data_count = r_count;
    assign head       = r_head;
    assign tail       = r_tail;
    assign d_out      = r_dout;

endmodule

// File: tb/tb_fifo_ctrl_core.sv
// tb/tb_fifo_ctrl_core.sv - scoreboard bench for fifo_ctrl_core against a queue-based reference model
module tb_fifo_ctrl_core;

    localparam logic [2:0] S_INIT   = 3'b000;
    localparam logic [2:0] S_WRITE  = 3'b001;
    localparam logic [2:0] S_WR_ERR = 3'b010;
    localparam logic [2:0] S_NO_OP  = 3'b011;
    localparam logic [2:0] S_READ   = 3'b100;
    localparam logic [2:0] S_RD_ERR = 3'b101;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic [2:0]  head;
    logic [2:0]  tail;

    fifo_ctrl_core #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  cnt;
        logic [2:0]  hd;
        logic [2:0]  tl;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int          mh;
    int          mt;
    logic [31:0] md;
    int          n_pass;
    int          n_total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // One cycle of stimulus; the reference model decides the expected outcome from queue occupancy.
    task automatic drive(input logic rst, input logic wr, input logic rd, input logic [31:0] din);
        exp_t e;
        logic [2:0] st;
        @(negedge clk);
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        d_in  = din;
        if (rst) begin
            mq.delete();
            mh = 0;
            mt = 0;
            md = '0;
            st = S_INIT;
        end else if (wr && !rd) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(din);
                mt = (mt + 1) % DEPTH;
                st = S_WRITE;
            end else begin
                st = S_WR_ERR;
            end
        end else if (rd && !wr) begin
            if (mq.size() > 0) begin
                md = mq.pop_front();
                mh = (mh + 1) % DEPTH;
                st = S_READ;
            end else begin
                st = S_RD_ERR;
            end
        end else begin
            st = S_NO_OP;
        end
        e.st  = st;
        e.cnt = 4'(mq.size());
        e.hd  = 3'(mh);
        e.tl  = 3'(mt);
        e.d   = md;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",      {29'd0, state},      {29'd0, e.st});
                chk("data_count", {28'd0, data_count}, {28'd0, e.cnt});
                chk("head",       {29'd0, head},       {29'd0, e.hd});
                chk("tail",       {29'd0, tail},       {29'd0, e.tl});
                chk("d_out",      d_out,               e.d);
            end
        end
    end

    initial begin
        int bias;
        n_pass  = 0;
        n_total = 0;
        mh      = 0;
        mt      = 0;
        md      = '0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = '0;

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 1'b0, 32'(i * 32'h11));
        drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, $urandom);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b1, 32'h1234_5678);

        drive(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, $urandom);
        drive(1'b1, 1'b1, 1'b0, 32'h5555_5555);
        drive(1'b0, 1'b0, 1'b1, 32'h0);

        bias = 75;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) bias = 100 - bias;
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 99) < bias),
                  ($urandom_range(0, 99) < (100 - bias)),
                  $urandom);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
